// File: rtl/dbg_host_if.sv
// Command/response handshake between a debug-command issuer (master) and the
// dbg_host serializer (slave).
interface dbg_host_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_wr;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;

  modport master (
    output cmd_valid, cmd_wr, cmd_addr, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dbg_host.sv
// Host end of the serial debug link: turns single-byte read/write commands into
// 8N1 debugger packets and collects the one-byte read reply.
module dbg_host #(
  parameter int CLKS_PER_BIT   = 1302,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic         clk,
  input  logic         rst,
  dbg_host_if.slave    bus,
  input  logic         rx,
  output logic         tx
);

  localparam int BW = $clog2(CLKS_PER_BIT + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] HALF_LAST = BW'(CLKS_PER_BIT / 2 - 1);
  // The FSM leaves on the edge where the counter steps onto TIMEOUT_CYCLES-1.
  localparam logic [TW-1:0] TO_FIRE   = TW'(TIMEOUT_CYCLES - 2);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_RX, DONE} state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  state_t        state;
  logic          cmd_ready_q;
  logic          rsp_valid_q;
  logic [7:0]    rsp_rdata_q;
  logic          rsp_err_q;

  logic          cap_wr;
  logic [15:0]   cap_addr;
  logic [7:0]    cap_wdata;
  logic [2:0]    byte_idx;
  logic [3:0]    bit_idx;
  logic [BW-1:0] tx_cnt;
  logic [TW-1:0] to_cnt;
  logic [7:0]    res_data;
  logic          res_err;
  logic          res_load;
  logic [7:0]    cur_byte;
  logic [2:0]    last_byte;

  rx_state_t     rx_state;
  logic          rx_s1, rx_s2, rx_prev;
  logic [BW-1:0] rx_cnt;
  logic [2:0]    rx_bits;
  logic [7:0]    rx_shift;
  logic          rx_done;
  logic [7:0]    rx_data;
  logic          rx_ferr;
  logic          rx_armed;

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

  assign last_byte = cap_wr ? 3'd5 : 3'd4;

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    cur_byte = 8'h00;
    case (byte_idx)
      3'd0:    cur_byte = cap_wr ? 8'h02 : 8'h01;
      3'd1:    cur_byte = cap_addr[7:0];
      3'd2:    cur_byte = cap_addr[15:8];
      3'd3:    cur_byte = 8'h01;
      3'd4:    cur_byte = 8'h00;
      3'd5:    cur_byte = cap_wdata;
      default: cur_byte = 8'h00;
    endcase
  end

  // NOTE: sequential state uses non-blocking (<=) so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      tx          <= 1'b1;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
      rsp_err_q   <= 1'b0;
      cap_wr      <= 1'b0;
      cap_addr    <= 16'h0000;
      cap_wdata   <= 8'h00;
      byte_idx    <= 3'd0;
      bit_idx     <= 4'd0;
      tx_cnt      <= '0;
      to_cnt      <= '0;
      res_data    <= 8'h00;
      res_err     <= 1'b0;
      res_load    <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cmd_valid && cmd_ready_q) begin
            cap_wr      <= bus.cmd_wr;
            cap_addr    <= bus.cmd_addr;
            cap_wdata   <= bus.cmd_wdata;
            byte_idx    <= 3'd0;
            bit_idx     <= 4'd0;
            tx_cnt      <= '0;
            tx          <= 1'b0;
            cmd_ready_q <= 1'b0;
            res_err     <= 1'b0;
            res_load    <= 1'b0;
            state       <= SEND;
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end

        SEND: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (bit_idx == 4'd9) begin
              if (byte_idx == last_byte) begin
                tx     <= 1'b1;
                to_cnt <= '0;
                state  <= cap_wr ? DONE : WAIT_RX;
              end else begin
                byte_idx <= byte_idx + 3'd1;
                bit_idx  <= 4'd0;
                tx       <= 1'b0;
              end
            end else begin
              // bit_idx names the bit just finished: 0 = start, 1..8 = data.
              bit_idx <= bit_idx + 4'd1;
              tx      <= (bit_idx == 4'd8) ? 1'b1 : cur_byte[bit_idx[2:0]];
            end
          end else begin
            tx_cnt <= tx_cnt + BW'(1);
          end
        end

        WAIT_RX: begin
          to_cnt <= to_cnt + TW'(1);
          if (rx_done && rx_armed) begin
            res_data <= rx_data;
            res_err  <= rx_ferr;
            res_load <= !rx_ferr;
            state    <= DONE;
          end else if (to_cnt == TO_FIRE) begin
            res_err <= 1'b1;
            state   <= DONE;
          end
        end

        DONE: begin
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= res_err;
          if (res_load) rsp_rdata_q <= res_data;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Receiver runs freely; rx_armed marks a frame whose start edge fell inside WAIT_RX.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bits  <= 3'd0;
      rx_shift <= 8'h00;
      rx_done  <= 1'b0;
      rx_data  <= 8'h00;
      rx_ferr  <= 1'b0;
      rx_armed <= 1'b0;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      rx_done <= 1'b0;

      if (state != WAIT_RX) rx_armed <= 1'b0;
      else if (rx_state == RX_IDLE && rx_prev && !rx_s2) rx_armed <= 1'b1;

      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_s2) begin
            rx_cnt   <= '0;
            rx_state <= RX_START;
          end
        end

        RX_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt   <= '0;
            rx_bits  <= 3'd0;
            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + BW'(1);
          end
        end

        RX_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s2, rx_shift[7:1]};
            if (rx_bits == 3'd7) rx_state <= RX_STOP;
            else                 rx_bits  <= rx_bits + 3'd1;
          end else begin
            rx_cnt <= rx_cnt + BW'(1);
          end
        end

        RX_STOP: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_done  <= 1'b1;
            rx_data  <= rx_shift;
            rx_ferr  <= !rx_s2;
            rx_state <= RX_IDLE;
          end else begin
            rx_cnt <= rx_cnt + BW'(1);
          end
        end

        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dbg_host.sv
// Directed bench for dbg_host: TX bytes and responses are checked against
// scoreboard queues filled when each command or reply is driven.
module tb_dbg_host;
  localparam int C = 16;
  localparam int T = 2000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rx  = 1'b1;
  logic tx;

  dbg_host_if bus();

  dbg_host #(.CLKS_PER_BIT(C), .TIMEOUT_CYCLES(T)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .rx  (rx),
    .tx  (tx)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic       err;
    logic [7:0] rdata;
    logic       chk_data;
  } rsp_t;

  logic [7:0] exp_tx_q[$];
  rsp_t       exp_rsp_q[$];

  int checks   = 0;
  int failures = 0;
  int rsp_cnt  = 0;
  int rsp_cyc  = 0;
  logic rsp_ready_at = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // TX monitor: decodes 8N1 frames at mid-bit and pops the expected byte.
  int         mon_off = -1;
  logic [7:0] mon_byte = 8'h00;
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      mon_off = -1;
    end else if (mon_off < 0) begin
      if (tx === 1'b0) mon_off = 1;
    end else begin
      if (mon_off == C - 1) check("tx_start_width", 32'(tx), 32'd0);
      if ((mon_off % C) == C / 2 && (mon_off / C) inside {[1:8]})
        mon_byte[3'(mon_off / C - 1)] = tx;
      if (mon_off == 9 * C + C / 2) begin
        check("tx_stop_bit", 32'(tx), 32'd1);
        if (exp_tx_q.size() == 0) begin
          checks++;
          failures++;
          $error("FAIL tx_unexpected_byte observed=0x%0h expected=none", mon_byte);
        end else begin
          check("tx_byte", 32'(mon_byte), 32'(exp_tx_q.pop_front()));
        end
        mon_off = -1;
      end else begin
        mon_off++;
      end
    end
  end

  // Response monitor.
  rsp_t mon_r;
  always @(negedge clk) begin
    if (rst === 1'b1 && bus.rsp_valid === 1'b1) begin
      rsp_cnt++;
      rsp_cyc      = cyc;
      rsp_ready_at = bus.cmd_ready;
      if (exp_rsp_q.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL rsp_unexpected observed=err%0b/0x%0h expected=none", bus.rsp_err, bus.rsp_rdata);
      end else begin
        mon_r = exp_rsp_q.pop_front();
        check("rsp_err", 32'(bus.rsp_err), 32'(mon_r.err));
        if (mon_r.chk_data) check("rsp_rdata", 32'(bus.rsp_rdata), 32'(mon_r.rdata));
      end
    end
  end

  // Called just after a negedge; acceptance happens on the following posedge.
  task automatic issue(input logic wr, input logic [15:0] addr, input logic [7:0] wd,
                       input bit hold, output int acc);
    check("ready_before_cmd", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_wr    = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wd;
    acc = cyc;
    exp_tx_q.push_back(wr ? 8'h02 : 8'h01);
    exp_tx_q.push_back(addr[7:0]);
    exp_tx_q.push_back(addr[15:8]);
    exp_tx_q.push_back(8'h01);
    exp_tx_q.push_back(8'h00);
    if (wr) exp_tx_q.push_back(wd);
    @(negedge clk);
    if (!hold) bus.cmd_valid = 1'b0;
    check("ready_drop", 32'(bus.cmd_ready), 32'd0);
    check("tx_start_first", 32'(tx), 32'd0);
  endtask

  task automatic wait_rsp(input int prev, input int budget, input string tag);
    int k = 0;
    while (rsp_cnt == prev && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (rsp_cnt == prev) begin
      checks++;
      failures++;
      $error("FAIL %s_rsp_wait observed=none expected=rsp_valid", tag);
    end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (C) @(negedge clk);
    end
    rx = stop;
    repeat (C) @(negedge clk);
    rx = 1'b1;
  endtask

  initial begin
    int acc;
    int prev;
    int e;

    bus.cmd_valid = 1'b0;
    bus.cmd_wr    = 1'b0;
    bus.cmd_addr  = 16'h0000;
    bus.cmd_wdata = 8'h00;

    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rdata", 32'(bus.rsp_rdata), 32'h00);
    check("rst_err", 32'(bus.rsp_err), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Write 0x1234 <- 0xA5.
    prev = rsp_cnt;
    exp_rsp_q.push_back('{err: 1'b0, rdata: 8'h00, chk_data: 1'b0});
    issue(1'b1, 16'h1234, 8'hA5, 1'b0, acc);
    wait_rsp(prev, 60 * C + 50, "wr");
    check("wr_latency", 32'(rsp_cyc - acc), 32'(60 * C + 2));
    check("wr_ready_at_rsp", 32'(rsp_ready_at), 32'd0);
    wait_until(rsp_cyc + 1);
    check("wr_ready_after_rsp", 32'(bus.cmd_ready), 32'd1);
    check("wr_tx_all_bytes", 32'(exp_tx_q.size()), 32'd0);

    // Read 0x0300, reply 0x5A 40 cycles after TX end.
    prev = rsp_cnt;
    exp_rsp_q.push_back('{err: 1'b0, rdata: 8'h5A, chk_data: 1'b1});
    issue(1'b0, 16'h0300, 8'hEE, 1'b0, acc);
    e = acc + 50 * C + 1;
    wait_until(e);
    check("rd_tx_all_bytes", 32'(exp_tx_q.size()), 32'd0);
    check("rd_tx_idle", 32'(tx), 32'd1);
    wait_until(e + 40);
    send_rx(8'h5A, 1'b1);
    wait_rsp(prev, 200, "rd");

    // Read with no reply: timeout, rdata keeps 0x5A.
    repeat (3) @(negedge clk);
    prev = rsp_cnt;
    exp_rsp_q.push_back('{err: 1'b1, rdata: 8'h5A, chk_data: 1'b1});
    issue(1'b0, 16'h0456, 8'h00, 1'b0, acc);
    wait_rsp(prev, 50 * C + T + 50, "to");
    check("to_latency", 32'(rsp_cyc - acc), 32'(50 * C + 1 + T));

    // Reply with stop bit forced low: framing error.
    repeat (3) @(negedge clk);
    prev = rsp_cnt;
    exp_rsp_q.push_back('{err: 1'b1, rdata: 8'h00, chk_data: 1'b0});
    issue(1'b0, 16'h0300, 8'h00, 1'b0, acc);
    wait_until(acc + 50 * C + 1 + 40);
    send_rx(8'hC3, 1'b0);
    wait_rsp(prev, 200, "ferr");

    // 4-cycle glitch in WAIT_RX is ignored; later 0x33 is returned.
    repeat (3) @(negedge clk);
    prev = rsp_cnt;
    exp_rsp_q.push_back('{err: 1'b0, rdata: 8'h33, chk_data: 1'b1});
    issue(1'b0, 16'h0301, 8'h00, 1'b0, acc);
    wait_until(acc + 50 * C + 1 + 40);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (60) @(negedge clk);
    check("glitch_no_rsp", 32'(rsp_cnt), 32'(prev));
    send_rx(8'h33, 1'b1);
    wait_rsp(prev, 200, "glitch");

    // Stray 0xFF in IDLE, then a read with cmd_valid held and fields changed during SEND.
    repeat (3) @(negedge clk);
    prev = rsp_cnt;
    send_rx(8'hFF, 1'b1);
    repeat (20) @(negedge clk);
    check("stray_no_rsp", 32'(rsp_cnt), 32'(prev));
    exp_rsp_q.push_back('{err: 1'b0, rdata: 8'h11, chk_data: 1'b1});
    issue(1'b0, 16'h7F80, 8'h00, 1'b1, acc);
    bus.cmd_addr = 16'hFFFF;
    bus.cmd_wr   = 1'b1;
    e = acc + 50 * C + 1;
    wait_until(e);
    bus.cmd_valid = 1'b0;
    bus.cmd_wr    = 1'b0;
    check("hold_tx_all_bytes", 32'(exp_tx_q.size()), 32'd0);
    wait_until(e + 40);
    send_rx(8'h11, 1'b1);
    wait_rsp(prev, 200, "hold");
    repeat (20) @(negedge clk);
    check("hold_no_second_packet", 32'(tx), 32'd1);

    // Reset in the middle of the third byte of a write.
    prev = rsp_cnt;
    issue(1'b1, 16'hBEEF, 8'h77, 1'b0, acc);
    wait_until(acc + 25 * C);
    #2 rst = 1'b0;
    #1;
    check("midrst_tx", 32'(tx), 32'd1);
    check("midrst_ready", 32'(bus.cmd_ready), 32'd1);
    check("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    repeat (3) @(negedge clk);
    exp_tx_q.delete();
    rst = 1'b1;
    repeat (100) @(negedge clk);
    check("midrst_no_rsp", 32'(rsp_cnt), 32'(prev));
    check("midrst_tx_idle", 32'(tx), 32'd1);

    prev = rsp_cnt;
    exp_rsp_q.push_back('{err: 1'b0, rdata: 8'h00, chk_data: 1'b0});
    issue(1'b1, 16'h00C3, 8'h3C, 1'b0, acc);
    wait_rsp(prev, 60 * C + 50, "wr2");
    check("wr2_latency", 32'(rsp_cyc - acc), 32'(60 * C + 2));
    check("wr2_tx_all_bytes", 32'(exp_tx_q.size()), 32'd0);

    repeat (20) @(negedge clk);
    check("rsp_queue_empty", 32'(exp_rsp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dbg_host.md
# dbg_host

Serial debug-protocol initiator: the host end of the link served by the `dbg` block. It accepts single-byte CPU-bus read/write commands on a parallel handshake and serializes them as debugger packets on an 8N1 UART TX line. For reads, it waits for the one-byte reply on the UART RX line and returns it with an error flag. The block lets on-chip test logic, or a second board, drive the `dbg` block exactly as the PC debugger does, for loopback self-test.

## Interface
- `CLKS_PER_BIT`, 1302, clock cycles per UART bit (50 MHz / 38400 baud).
- `TIMEOUT_CYCLES`, 1000000, cycles to wait for a read reply before flagging an error.
- `clk`  in  1  system clock (50 MHz); all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  the block accepts a command when `cmd_valid & cmd_ready`.
- `cmd_wr`  in  1  1 = CPU memory write, 0 = CPU memory read.
- `cmd_addr`  in  16  CPU address.
- `cmd_wdata`  in  8  write data; ignored for reads.
- `rsp_valid`  out  1  one-cycle pulse when a command completes.
- `rsp_rdata`  out  8  read data; holds its value until the next `rsp_valid`.
- `rsp_err`  out  1  qualifies `rsp_valid`: read timeout or RX framing error.
- `rx`  in  1  UART RX from the `dbg` block's `tx`.
- `tx`  out  1  UART TX to the `dbg` block's `rx`.

## Operation
- Packet formats, bytes sent LSB first:
  - Read: `0x01`, addr[7:0], addr[15:8], `0x01`, `0x00`. This is 5 bytes, and the reply is 1 data byte.
  - Write: `0x02`, addr[7:0], addr[15:8], `0x01`, `0x00`, wdata. This is 6 bytes, and there is no reply.
- Command fields are captured on acceptance. Later changes to `cmd_*` have no effect until the next acceptance.
- FSM states are IDLE, SEND, WAIT_RX and DONE:
  - IDLE: `cmd_ready`=1. On acceptance, load the byte index to 0 and go to SEND.
  - SEND: transmit packet bytes back-to-back with no idle bits between frames. After the last stop bit, go to WAIT_RX for a read or DONE for a write.
  - WAIT_RX: the timeout counter runs from 0.
    - Completed RX frame with stop bit = 1: go to DONE with the data.
    - Stop bit = 0: go to DONE with `rsp_err`=1.
    - Counter reaches `TIMEOUT_CYCLES`-1: go to DONE with `rsp_err`=1, and `rsp_rdata` is unchanged.
  - DONE: assert `rsp_valid` for one cycle, then return to IDLE.
- UART TX sends a start bit of 0, then 8 data bits LSB first, then a stop bit of 1. Each bit lasts exactly `CLKS_PER_BIT` cycles. `tx`=1 whenever the block is not sending.
- UART RX:
  - `rx` passes through a 2-flop synchronizer, reset to 1.
  - A falling edge while the receiver is idle starts a frame.
  - The start bit is re-checked at `CLKS_PER_BIT/2`; if it is 1 the frame is a glitch and is discarded.
  - Data and stop bits are sampled every `CLKS_PER_BIT` after that mid-start point.
- The receiver runs continuously, but frames completing outside WAIT_RX are discarded. A frame already in progress when WAIT_RX is entered is also discarded; only a frame whose start edge falls inside WAIT_RX is used.
- The bit counter is at least 11 bits wide, and the timeout counter is at least 20 bits, sized by `$clog2`.

## Timing
- Reset values: `tx`=1, `cmd_ready`=1, `rsp_valid`=0, `rsp_rdata`=0x00, `rsp_err`=0. The FSM resets to IDLE and all counters to 0.
- Reset mid-packet aborts immediately: `tx` goes to 1 asynchronously and no response is issued.
- `tx` start bit begins on the cycle after acceptance. `cmd_ready` drops on that same cycle.
- Write latency: acceptance to `rsp_valid` is 60·`CLKS_PER_BIT` + 2 cycles.
- Read latency: acceptance to the end of TX is 50·`CLKS_PER_BIT` + 1 cycles. After that, `rsp_valid` arrives 2 cycles after the RX stop-bit sample point.
- `cmd_ready` returns to 1 on the cycle after `rsp_valid`. Back-to-back commands are therefore separated by at least 2 cycles.
- `cmd_valid` asserted while `cmd_ready`=0 is ignored. There is no queuing.
- `rsp_rdata` updates on the same cycle `rsp_valid` is asserted.

## Test plan
All scenarios use `CLKS_PER_BIT`=16 and `TIMEOUT_CYCLES`=2000.
- Write `cmd_addr`=0x1234, `cmd_wdata`=0xA5 -> `tx` carries frames 02 34 12 01 00 A5, each start bit 16 cycles wide. `rsp_valid` arrives 962 cycles after acceptance with `rsp_err`=0.
- Read 0x0300, with the bench model replying 0x5A 40 cycles after the TX ends -> `tx` carries 01 00 03 01 00, then `rsp_valid` with `rsp_rdata`=0x5A and `rsp_err`=0.
- Read with no reply -> `rsp_valid` arrives 2000 cycles after the TX ends with `rsp_err`=1 and `rsp_rdata` unchanged (0x5A).
- Reply frame with the stop bit forced to 0 -> `rsp_err`=1. Separately, a 4-cycle low glitch on `rx` during WAIT_RX causes no response, and a later valid 0x33 returns `rsp_rdata`=0x33.
- Stray RX byte 0xFF in IDLE followed by a read with reply 0x11 -> `rsp_rdata`=0x11. `cmd_valid` held high during SEND causes no second packet.
- `rst` pulsed low in the middle of the third write byte -> `tx`=1 and `cmd_ready`=1 immediately with no `rsp_valid`, and the next write packet is emitted correctly from byte 0.
